// File: rtl/cache_pkg.sv
// Types and helpers shared by the cache array and its miss handler.
package cache_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWbReq  = 3'd1,
        StRdReq  = 3'd2,
        StRdWait = 3'd3,
        StFill   = 3'd4
    } miss_state_e;

    function automatic int unsigned offset_w(input int unsigned line_bytes);
        return $clog2(line_bytes);
    endfunction

    // Clears the byte-offset bits; callers narrow the 64-bit result to their address width.
    function automatic logic [63:0] line_align(input logic [63:0] addr,
                                               input int unsigned line_bytes);
        logic [63:0] mask;
        mask = ~((64'd1 << offset_w(line_bytes)) - 64'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/cache_perf_counter.sv
// Saturating 32-bit event counter; only built when CACHE_MISS_HANDLER_PERF_EN is defined.
`ifdef CACHE_MISS_HANDLER_PERF_EN
module cache_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count_o = count_q;

endmodule
`endif

// File: rtl/cache_miss_handler.sv
// Blocking miss handler: optional victim write-back, line read, then a one-cycle fill pulse.
// Define CACHE_MISS_HANDLER_PERF_EN to add saturating miss/write-back/stall counters.
module cache_miss_handler
    import cache_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned B     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_valid_i,
    output logic             miss_ready_o,
    input  logic [WIDTH-1:0] miss_addr_i,
    input  logic             victim_dirty_i,
    input  logic [WIDTH-1:0] victim_addr_i,
    input  logic [B*8-1:0]   victim_data_i,
    output logic             mem_req_valid_o,
    input  logic             mem_req_ready_i,
    output logic             mem_req_we_o,
    output logic [WIDTH-1:0] mem_req_addr_o,
    output logic [B*8-1:0]   mem_req_data_o,
    input  logic             mem_resp_valid_i,
    input  logic [B*8-1:0]   mem_resp_data_i,
    output logic             fill_valid_o,
    output logic [WIDTH-1:0] fill_addr_o,
    output logic [B*8-1:0]   fill_data_o,
    output logic             busy_o
`ifdef CACHE_MISS_HANDLER_PERF_EN
    ,
    output logic [31:0]      miss_count_o,
    output logic [31:0]      wb_count_o,
    output logic [31:0]      stall_cycles_o
`endif
);

    miss_state_e      state_q, state_d;
    logic [WIDTH-1:0] miss_addr_q, victim_addr_q;
    logic [B*8-1:0]   victim_data_q, fill_data_q;
    logic             victim_dirty_q;
    logic             accept, resp_take;
    logic [WIDTH-1:0] miss_aligned, victim_aligned;

    assign miss_aligned   = WIDTH'(line_align(64'(miss_addr_i), B));
    assign victim_aligned = WIDTH'(line_align(64'(victim_addr_i), B));
    assign accept         = (state_q == StIdle) && miss_valid_i;
    assign resp_take      = (state_q == StRdWait) && mem_resp_valid_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (miss_valid_i) state_d = victim_dirty_i ? StWbReq : StRdReq;
            StWbReq:  if (mem_req_ready_i) state_d = StRdReq;
            StRdReq:  if (mem_req_ready_i) state_d = StRdWait;
            StRdWait: if (mem_resp_valid_i) state_d = StFill;
            StFill:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            miss_addr_q    <= '0;
            victim_addr_q  <= '0;
            victim_data_q  <= '0;
            victim_dirty_q <= 1'b0;
            fill_data_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                miss_addr_q    <= miss_aligned;
                victim_addr_q  <= victim_aligned;
                victim_data_q  <= victim_data_i;
                victim_dirty_q <= victim_dirty_i;
            end
            if (resp_take) begin
                fill_data_q <= mem_resp_data_i;
            end
        end
    end

    // Outputs come only from registered state, so they stay stable under backpressure.
    always_comb begin
        miss_ready_o    = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_we_o    = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_data_o  = '0;
        fill_valid_o    = 1'b0;
        fill_addr_o     = '0;
        fill_data_o     = '0;
        unique case (state_q)
            StIdle: miss_ready_o = 1'b1;
            StWbReq: begin
                mem_req_valid_o = 1'b1;
                mem_req_we_o    = victim_dirty_q;
                mem_req_addr_o  = victim_addr_q;
                mem_req_data_o  = victim_data_q;
            end
            StRdReq: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = miss_addr_q;
            end
            StFill: begin
                fill_valid_o = 1'b1;
                fill_addr_o  = miss_addr_q;
                fill_data_o  = fill_data_q;
            end
            default: ;
        endcase
    end

    assign busy_o = (state_q != StIdle);

`ifdef CACHE_MISS_HANDLER_PERF_EN
    logic wb_hs, stall_cyc;

    assign wb_hs     = (state_q == StWbReq) && mem_req_ready_i;
    assign stall_cyc = (((state_q == StWbReq) || (state_q == StRdReq)) && !mem_req_ready_i)
                       || (state_q == StRdWait);

    cache_perf_counter u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (accept),
        .count_o (miss_count_o)
    );

    cache_perf_counter u_wb_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (wb_hs),
        .count_o (wb_count_o)
    );

    cache_perf_counter u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall_cyc),
        .count_o (stall_cycles_o)
    );
`endif

endmodule

// File: tb/tb_cache_miss_handler.sv
// Self-checking bench for cache_miss_handler: directed scenarios plus randomized misses.
module tb_cache_miss_handler;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid_i, miss_ready_o, victim_dirty_i;
    logic [31:0] miss_addr_i, victim_addr_i, victim_data_i;
    logic        mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
    logic [31:0] mem_req_addr_o, mem_req_data_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_resp_data_i;
    logic        fill_valid_o, busy_o;
    logic [31:0] fill_addr_o, fill_data_o;
`ifdef CACHE_MISS_HANDLER_PERF_EN
    logic [31:0] miss_count_o, wb_count_o, stall_cycles_o;
`endif

    cache_miss_handler #(.WIDTH(32), .B(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_valid_i     (miss_valid_i),
        .miss_ready_o     (miss_ready_o),
        .miss_addr_i      (miss_addr_i),
        .victim_dirty_i   (victim_dirty_i),
        .victim_addr_i    (victim_addr_i),
        .victim_data_i    (victim_data_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_we_o     (mem_req_we_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_data_o   (mem_req_data_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .fill_valid_o     (fill_valid_o),
        .fill_addr_o      (fill_addr_o),
        .fill_data_o      (fill_data_o),
        .busy_o           (busy_o)
`ifdef CACHE_MISS_HANDLER_PERF_EN
        ,
        .miss_count_o     (miss_count_o),
        .wb_count_o       (wb_count_o),
        .stall_cycles_o   (stall_cycles_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations gathered by run_miss for the scenario tasks to judge.
    logic        obs_we[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          fill_cnt, fill_cyc, unstable, timeout;
    logic        ready_after;
    logic [31:0] fill_addr_seen, fill_data_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return (a / 32'd4) * 32'd4;
    endfunction

    // Presents one miss and plays memory with the given stalls; records what the DUT did.
    task automatic run_miss(input logic [31:0] a, input logic d, input logic [31:0] va,
                            input logic [31:0] vd, input logic [31:0] rd,
                            input int ws, input int rs, input int rdly);
        int k, waited, wcnt;
        logic pend, rd_hs, resp_sent, filled, hwe;
        logic [31:0] ha, hd;
        obs_we.delete(); obs_addr.delete(); obs_data.delete();
        fill_cnt = 0; fill_cyc = -1; unstable = 0; timeout = 0; ready_after = 1'b0;
        fill_addr_seen = '0; fill_data_seen = '0;
        k = 0;
        while (!miss_ready_o && k < 50) begin tick(); k++; end
        if (!miss_ready_o) timeout = 1;
        miss_valid_i = 1'b1; miss_addr_i = a; victim_dirty_i = d;
        victim_addr_i = va; victim_data_i = vd;
        tick();
        miss_valid_i = 1'b0; miss_addr_i = $urandom; victim_addr_i = $urandom;
        victim_data_i = $urandom; victim_dirty_i = 1'b0;
        pend = 0; waited = 0; wcnt = 0; rd_hs = 0; resp_sent = 0; filled = 0;
        hwe = 0; ha = '0; hd = '0;
        k = 1;
        while (k <= 300) begin
            mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = $urandom;
            if (filled) begin
                ready_after = miss_ready_o;
                if (fill_valid_o) fill_cnt++;
                break;
            end
            if (mem_req_valid_o) begin
                if (!pend) begin
                    pend = 1; waited = 0;
                    hwe = mem_req_we_o; ha = mem_req_addr_o; hd = mem_req_data_o;
                end else if (mem_req_we_o !== hwe || mem_req_addr_o !== ha
                             || mem_req_data_o !== hd) begin
                    unstable++;
                end
                if (waited >= (hwe ? ws : rs)) begin
                    mem_req_ready_i = 1'b1;
                    obs_we.push_back(hwe); obs_addr.push_back(ha); obs_data.push_back(hd);
                    pend = 0;
                    if (!hwe) rd_hs = 1;
                end else begin
                    waited++;
                end
            end else if (rd_hs && !resp_sent) begin
                if (wcnt == rdly) begin
                    mem_resp_valid_i = 1'b1; mem_resp_data_i = rd; resp_sent = 1;
                end
                wcnt++;
            end
            if (fill_valid_o) begin
                fill_cnt++; fill_cyc = k; filled = 1;
                fill_addr_seen = fill_addr_o; fill_data_seen = fill_data_o;
            end
            tick();
            k++;
        end
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
        if (!filled) timeout = 1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        miss_valid_i = 0; miss_addr_i = 0; victim_dirty_i = 0; victim_addr_i = 0;
        victim_data_i = 0; mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_resp_data_i = 0;
        tick(); tick();
        n_cmp++; if (miss_ready_o !== 1'b1 || busy_o !== 1'b0 || mem_req_valid_o !== 1'b0
                     || fill_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle ready=%b busy=%b req=%b fill=%b (want 1 0 0 0)",
                              miss_ready_o, busy_o, mem_req_valid_o, fill_valid_o);
        end
        rst = 1'b1;
        tick();
        // Walk a clean miss into RD_WAIT, then reset asynchronously mid-cycle.
        miss_valid_i = 1'b1; miss_addr_i = 32'h0000_5678; mem_req_ready_i = 1'b1;
        tick();
        miss_valid_i = 1'b0;
        tick();
        mem_req_ready_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_prewait busy=%b req=%b (want 1 0)", busy_o,
                              mem_req_valid_o);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (miss_ready_o !== 1'b1 || busy_o !== 1'b0 || mem_req_valid_o !== 1'b0
                     || mem_req_we_o !== 1'b0 || mem_req_addr_o !== 32'd0
                     || mem_req_data_o !== 32'd0 || fill_valid_o !== 1'b0
                     || fill_addr_o !== 32'd0 || fill_data_o !== 32'd0) begin
            n_bad++; $display("FAIL reset_mid rdy=%b busy=%b req=%b we=%b a=%h d=%h f=%b fa=%h fd=%h (want rdy=1 rest 0)",
                              miss_ready_o, busy_o, mem_req_valid_o, mem_req_we_o,
                              mem_req_addr_o, mem_req_data_o, fill_valid_o, fill_addr_o,
                              fill_data_o);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid_i = (i < 2); mem_resp_data_i = 32'h1111_2222;
            tick();
            n_cmp++; if (fill_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                n_bad++; $display("FAIL reset_late_resp cyc=%0d fill=%b busy=%b (want 0 0)", i,
                                  fill_valid_o, busy_o);
            end
        end
        mem_resp_valid_i = 1'b0;
    endtask

    task automatic test_clean_miss();
        run_miss(32'h0000_1237, 1'b0, 32'h0000_0F0F, 32'h5555_5555, 32'hDEAD_BEEF, 0, 0, 0);
        n_cmp++; if (timeout != 0 || obs_we.size() != 1) begin
            n_bad++; $display("FAIL clean_reqs timeout=%0d reqs=%0d (want 0 1)", timeout,
                              obs_we.size());
        end else if (obs_we[0] !== 1'b0 || obs_addr[0] !== 32'h0000_1234 || obs_data[0] !== 0) begin
            n_bad++; $display("FAIL clean_read we=%b addr=%h data=%h (want 0 00001234 0)",
                              obs_we[0], obs_addr[0], obs_data[0]);
        end
        n_cmp++; if (fill_cnt != 1 || fill_cyc != 3 || fill_addr_seen !== 32'h0000_1234
                     || fill_data_seen !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL clean_fill cnt=%0d cyc=%0d addr=%h data=%h (want 1 3 00001234 deadbeef)",
                              fill_cnt, fill_cyc, fill_addr_seen, fill_data_seen);
        end
        n_cmp++; if (ready_after !== 1'b1) begin
            n_bad++; $display("FAIL clean_ready_after got=%b want=1", ready_after);
        end
    endtask

    task automatic test_dirty_miss();
        run_miss(32'h0000_1210, 1'b1, 32'h0000_0A10, 32'hCAFE_F00D, 32'h0BAD_F00D, 0, 0, 0);
        n_cmp++; if (timeout != 0 || obs_we.size() != 2) begin
            n_bad++; $display("FAIL dirty_reqs timeout=%0d reqs=%0d (want 0 2)", timeout,
                              obs_we.size());
        end else if (obs_we[0] !== 1'b1 || obs_addr[0] !== 32'h0000_0A10
                     || obs_data[0] !== 32'hCAFE_F00D || obs_we[1] !== 1'b0
                     || obs_addr[1] !== 32'h0000_1210 || obs_data[1] !== 0) begin
            n_bad++; $display("FAIL dirty_order wb=(%b %h %h) rd=(%b %h %h) want wb=(1 00000a10 cafef00d) rd=(0 00001210 0)",
                              obs_we[0], obs_addr[0], obs_data[0], obs_we[1], obs_addr[1],
                              obs_data[1]);
        end
        n_cmp++; if (fill_cnt != 1 || fill_cyc != 4 || fill_data_seen !== 32'h0BAD_F00D) begin
            n_bad++; $display("FAIL dirty_fill cnt=%0d cyc=%0d data=%h (want 1 4 0badf00d)",
                              fill_cnt, fill_cyc, fill_data_seen);
        end
    endtask

    task automatic test_backpressure();
        run_miss(32'h0000_3002, 1'b1, 32'h0000_7777, 32'h1234_5678, 32'h8765_4321, 5, 5, 0);
        n_cmp++; if (unstable != 0) begin
            n_bad++; $display("FAIL bp_stable changes=%0d want=0", unstable);
        end
        n_cmp++; if (obs_we.size() != 2 || fill_cnt != 1) begin
            n_bad++; $display("FAIL bp_handshakes reqs=%0d fills=%0d (want 2 1)", obs_we.size(),
                              fill_cnt);
        end
        n_cmp++; if (fill_cyc != 14 || fill_addr_seen !== 32'h0000_3000) begin
            n_bad++; $display("FAIL bp_latency cyc=%0d addr=%h (want 14 00003000)", fill_cyc,
                              fill_addr_seen);
        end
    endtask

    task automatic test_spurious_resp();
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid_i = 1'b1; mem_resp_data_i = $urandom;
            tick();
            n_cmp++; if (busy_o !== 1'b0 || fill_valid_o !== 1'b0 || miss_ready_o !== 1'b1) begin
                n_bad++; $display("FAIL spurious_resp cyc=%0d busy=%b fill=%b rdy=%b (want 0 0 1)",
                                  i, busy_o, fill_valid_o, miss_ready_o);
            end
        end
        mem_resp_valid_i = 1'b0;
    endtask

    task automatic test_overlap();
        int accepts, fills, overlap;
        accepts = 0; fills = 0; overlap = 0;
        miss_valid_i = 1'b1; miss_addr_i = 32'h0000_4441; victim_dirty_i = 1'b0;
        mem_req_ready_i = 1'b1; mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'hA5A5_0001;
        for (int i = 0; i < 12; i++) begin
            if (miss_valid_i && miss_ready_o) accepts++;
            if (miss_ready_o && busy_o) overlap++;
            if (fill_valid_o) begin
                fills++;
                if (fill_addr_o !== 32'h0000_4440 || fill_data_o !== 32'hA5A5_0001) overlap++;
            end
            tick();
        end
        miss_valid_i = 1'b0; mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
        n_cmp++; if (accepts != 3 || fills != 3 || overlap != 0) begin
            n_bad++; $display("FAIL overlap accepts=%0d fills=%0d bad=%0d (want 3 3 0)", accepts,
                              fills, overlap);
        end
        n_cmp++; if (miss_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL overlap_idle rdy=%b busy=%b (want 1 0)", miss_ready_o, busy_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, va, vd, rd;
        logic d;
        int ws, rs, rdly, exp_n, exp_cyc;
        for (int t = 0; t < 20; t++) begin
            a = $urandom; va = $urandom; vd = $urandom; rd = $urandom; d = 1'($urandom_range(0, 1));
            ws = $urandom_range(0, 3); rs = $urandom_range(0, 3); rdly = $urandom_range(0, 3);
            run_miss(a, d, va, vd, rd, ws, rs, rdly);
            exp_n   = d ? 2 : 1;
            exp_cyc = (d ? ws + 1 : 0) + (rs + 1) + (rdly + 1) + 1;
            n_cmp++; if (timeout != 0 || obs_we.size() != exp_n) begin
                n_bad++; $display("FAIL rand%0d_reqs timeout=%0d reqs=%0d want=%0d", t, timeout,
                                  obs_we.size(), exp_n);
            end else begin
                if (d && (obs_we[0] !== 1'b1 || obs_addr[0] !== align(va) || obs_data[0] !== vd)) begin
                    n_bad++; $display("FAIL rand%0d_wb got=(%b %h %h) want=(1 %h %h)", t, obs_we[0],
                                      obs_addr[0], obs_data[0], align(va), vd);
                end
                if (obs_we[exp_n-1] !== 1'b0 || obs_addr[exp_n-1] !== align(a)
                    || obs_data[exp_n-1] !== 32'd0) begin
                    n_bad++; $display("FAIL rand%0d_rd got=(%b %h %h) want=(0 %h 0)", t,
                                      obs_we[exp_n-1], obs_addr[exp_n-1], obs_data[exp_n-1],
                                      align(a));
                end
            end
            n_cmp++; if (fill_cnt != 1 || fill_cyc != exp_cyc || fill_addr_seen !== align(a)
                         || fill_data_seen !== rd || unstable != 0 || ready_after !== 1'b1) begin
                n_bad++; $display("FAIL rand%0d_fill cnt=%0d cyc=%0d addr=%h data=%h unst=%0d rdy=%b want 1 %0d %h %h 0 1",
                                  t, fill_cnt, fill_cyc, fill_addr_seen, fill_data_seen,
                                  unstable, ready_after, exp_cyc, align(a), rd);
            end
        end
    endtask

`ifdef CACHE_MISS_HANDLER_PERF_EN
    task automatic test_perf();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (miss_count_o !== 0 || wb_count_o !== 0 || stall_cycles_o !== 0) begin
            n_bad++; $display("FAIL perf_reset got=%0d %0d %0d want=0 0 0", miss_count_o,
                              wb_count_o, stall_cycles_o);
        end
        run_miss(32'h0000_0100, 1'b1, 32'h0000_0200, 32'h1, 32'h2, 3, 0, 0);
        run_miss(32'h0000_0300, 1'b1, 32'h0000_0400, 32'h3, 32'h4, 3, 0, 0);
        n_cmp++; if (miss_count_o !== 2 || wb_count_o !== 2 || stall_cycles_o !== 8) begin
            n_bad++; $display("FAIL perf_counts got=%0d %0d %0d want=2 2 8", miss_count_o,
                              wb_count_o, stall_cycles_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_backpressure();
        test_spurious_resp();
        test_overlap();
        test_random();
`ifdef CACHE_MISS_HANDLER_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_miss_handler.md
Name: cache_miss_handler

Overview:
- Memory-side stage directly downstream of the direct-mapped cache array.
- Accepts one miss at a time from the cache: missing address plus victim line state.
- Writes back a dirty victim, reads the missing line from memory, then returns it to the cache as a fill.
- Blocking: one outstanding miss, no internal queue.

Parameters:
- WIDTH, 32, address width in bits.
- B, 4, line size in bytes; line data is B*8 bits; offset bits = $clog2(B).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- miss_valid_i  in  1  cache presents a miss.
- miss_ready_o  out  1  handler can accept a miss.
- miss_addr_i  in  WIDTH  byte address that missed.
- victim_dirty_i  in  1  victim line valid and dirty.
- victim_addr_i  in  WIDTH  victim line address, rebuilt by the cache from stored tag and index.
- victim_data_i  in  B*8  victim line data.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts request.
- mem_req_we_o  out  1  1 = write-back, 0 = line read.
- mem_req_addr_o  out  WIDTH  line-aligned address; low offset bits are 0.
- mem_req_data_o  out  B*8  write data; 0 on reads.
- mem_resp_valid_i  in  1  read data valid. Writes get no response.
- mem_resp_data_i  in  B*8  read line data.
- fill_valid_o  out  1  one-cycle pulse; cache writes the line (valid=1, dirty=0).
- fill_addr_o  out  WIDTH  line-aligned miss address.
- fill_data_o  out  B*8  refilled line.
- busy_o  out  1  state != IDLE.

Behaviour:
- States: IDLE, WB_REQ, RD_REQ, RD_WAIT, FILL. 3-bit encoding.
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All captured registers are cleared.
  - Output values during reset: miss_ready_o=1; all other outputs 0.
- IDLE:
  - miss_ready_o=1.
  - On miss_valid_i & miss_ready_o, register the aligned miss address, victim_dirty_i, aligned victim address and victim data.
  - Go to WB_REQ if victim_dirty_i, else RD_REQ.
- WB_REQ:
  - Drive mem_req_valid_o=1, we=1, victim address and victim data.
  - On mem_req_ready_i, go to RD_REQ.
- RD_REQ:
  - Drive mem_req_valid_o=1, we=0, miss address, data=0.
  - On mem_req_ready_i, go to RD_WAIT.
- Request hold rule: while mem_req_valid_o=1 and ready is low, valid, we, addr and data hold stable. Valid never drops before the handshake.
- RD_WAIT:
  - On mem_resp_valid_i, capture mem_resp_data_i into the fill register and go to FILL.
  - No timeout.
- FILL:
  - fill_valid_o=1 for exactly one cycle, with fill_addr_o and fill_data_o.
  - Next state IDLE.
- miss_ready_o is high only in IDLE. A miss arriving in any other state is not accepted; the cache holds it.
- Address alignment: the low $clog2(B) bits of captured addresses are forced to 0.
- mem_resp_valid_i outside RD_WAIT is ignored, with no state change.
- Latency, clean miss, zero-wait memory:
  - Accept at cycle T.
  - RD_REQ at T+1, handshake at T+1.
  - RD_WAIT at T+2; response seen at T+2.
  - fill_valid_o at T+3; miss_ready_o high again at T+4.
- A dirty miss adds one WB_REQ cycle per cycle of write-back stall, minimum +1.
- Back-to-back misses: a new miss can be accepted in the first IDLE cycle after FILL.
- Reset mid-operation:
  - Any in-flight memory transaction is abandoned; no fill is produced.
  - The memory side must be reset in the same domain.

Optional Feature:
- Macro: CACHE_MISS_HANDLER_PERF_EN.
- When defined, adds three outputs:
  - miss_count_o (32): +1 per accepted miss.
  - wb_count_o (32): +1 per write-back handshake.
  - stall_cycles_o (32): +1 per cycle in WB_REQ/RD_REQ with ready low, or in RD_WAIT.
- Counters are saturating, not wrapping, and reset to 0.
- Without the macro, these ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package cache_pkg holds:
  - the state enum typedef (IDLE, WB_REQ, RD_REQ, RD_WAIT, FILL);
  - localparam functions for offset width;
  - a line-aligned address helper.
- The cache array can reuse the package.
- One natural sub-module, under the macro: cache_perf_counter, a single saturating 32-bit counter instantiated three times.
- The FSM stays in this module.

Test Plan:
- Reset: rst=0 mid-RD_WAIT → all outputs 0 except miss_ready_o=1. After release, a late mem_resp_valid_i produces no fill.
- Clean miss, zero-wait memory:
  - Stimulus: miss_addr_i=0x0000_1237, victim_dirty_i=0, mem_req_ready_i tied high, mem_resp_data_i=0xDEAD_BEEF the cycle after the read handshake.
  - Required: read request to 0x0000_1234; fill_valid_o one pulse with addr 0x0000_1234, data 0xDEAD_BEEF, 3 cycles after accept; miss_ready_o high the next cycle.
- Dirty miss:
  - Stimulus: victim_addr_i=0x0000_0A10, victim_data_i=0xCAFE_F00D, miss_addr_i=0x0000_1210.
  - Required: write request (we=1, 0x0000_0A10, 0xCAFE_F00D) first, then read request to 0x0000_1210, then fill.
- Backpressure: mem_req_ready_i low for 5 cycles in WB_REQ and in RD_REQ → request fields stable every cycle; exactly one handshake each.
- Spurious/overlap:
  - mem_resp_valid_i pulsed in IDLE → no state change.
  - miss_valid_i held during busy → not accepted until IDLE; then accepted exactly once.
- Perf (macro defined): two dirty misses with 3 stall cycles each → miss_count_o=2, wb_count_o=2, stall_cycles_o ≥ 6.
